// File: rtl/digit_scanner.sv
// digit_scanner: digit position scanner for multiplexed 7-segment displays.
// Produces scan position, one-hot digit select and blanking for N digits,
// with slot prescaler, scan direction, enable-mask skipping and dead time.
module digit_scanner #(
    parameter int unsigned N_DIGITS       = 8,
    parameter int unsigned POS_W          = 3,
    parameter int unsigned PRESCALE       = 50000,
    parameter int unsigned DEAD_CYC       = 4,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_dir,
    input  logic [N_DIGITS-1:0] i_digit_mask,
    output logic [POS_W-1:0]    o_pos,
    output logic [N_DIGITS-1:0] o_sel,
    output logic                o_blank,
    output logic                o_slot_tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]    DEAD_END = CNT_W'(DEAD_CYC);
    localparam logic [POS_W-1:0]    LAST_POS = POS_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] SEL_IDLE = SEL_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;
    logic                blank_q, blank_d;
    logic                tick_q, tick_d;
    logic [POS_W-1:0]    nxt_pos;
    logic [POS_W-1:0]    scan_idx;
    logic                found;
    logic [N_DIGITS-1:0] sel_onehot;

    // One rotation step in the requested direction, wrapping inside 0..N_DIGITS-1
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p, input logic up);
        if (up) begin
            return (p == LAST_POS) ? '0 : p + POS_W'(1);
        end
        return (p == '0) ? LAST_POS : p - POS_W'(1);
    endfunction

    // Next enabled position in rotation order; current digit is the last candidate
    always_comb begin
        nxt_pos  = pos_q;
        found    = 1'b0;
        scan_idx = pos_q;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            scan_idx = step_pos(scan_idx, i_dir);
            if (!found && i_digit_mask[scan_idx]) begin
                nxt_pos = scan_idx;
                found   = 1'b1;
            end
        end
    end

    // Slot counter, position update and select/blank decode from next state
    always_comb begin
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        tick_d     = 1'b0;
        sel_d      = SEL_IDLE;
        blank_d    = 1'b1;
        sel_onehot = '0;

        if (!i_en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d  = '0;
            pos_d  = nxt_pos;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        sel_onehot[pos_d] = 1'b1;
        if (i_en && (cnt_d >= DEAD_END) && i_digit_mask[pos_d]) begin
            sel_d   = SEL_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
            blank_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            pos_q   <= LAST_POS;
            sel_q   <= SEL_IDLE;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
        end
    end

    assign o_pos       = pos_q;
    assign o_sel       = sel_q;
    assign o_blank     = blank_q;
    assign o_slot_tick = tick_q;

endmodule

// File: tb/tb_digit_scanner.sv
// tb_digit_scanner: scoreboard bench for digit_scanner (4 digits, prescale 4, 1 dead cycle).
module tb_digit_scanner;

    localparam int N  = 4;
    localparam int PS = 4;
    localparam int DC = 1;

    typedef struct packed {
        logic [1:0] pos;
        logic [3:0] sel;
        logic       blank;
        logic       tick;
    } exp_t;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_en;
    logic       i_dir;
    logic [3:0] i_digit_mask;
    logic [1:0] o_pos;
    logic [3:0] o_sel;
    logic       o_blank;
    logic       o_slot_tick;

    exp_t exp_q[$];
    int   n_chk;
    int   n_pass;
    int   m_cnt;
    int   m_pos;
    int   tick_cnt;

    digit_scanner #(
        .N_DIGITS(4), .POS_W(2), .PRESCALE(4), .DEAD_CYC(1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_dir(i_dir),
        .i_digit_mask(i_digit_mask), .o_pos(o_pos), .o_sel(o_sel),
        .o_blank(o_blank), .o_slot_tick(o_slot_tick)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Count one comparison and report a mismatch
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: advance one clock with the current inputs, return expected outputs
    function automatic exp_t model_step();
        exp_t e;
        bit   hit;
        int   c;
        e.tick = 1'b0;
        if (!i_en) begin
            m_cnt = 0;
        end else if (m_cnt == PS - 1) begin
            m_cnt  = 0;
            e.tick = 1'b1;
            hit    = 0;
            for (int k = 1; k <= N; k++) begin
                c = i_dir ? (m_pos + k) % N : (m_pos + N - k) % N;
                if (!hit && i_digit_mask[c]) begin
                    m_pos = c;
                    hit   = 1;
                end
            end
        end else begin
            m_cnt = m_cnt + 1;
        end
        e.pos = 2'(m_pos);
        if (!i_en || m_cnt < DC || !i_digit_mask[m_pos]) begin
            e.sel   = 4'b1111;
            e.blank = 1'b1;
        end else begin
            e.sel   = 4'b1111 ^ 4'(1 << m_pos);
            e.blank = 1'b0;
        end
        return e;
    endfunction

    // Push expectation, clock once, pop and compare against the DUT
    task automatic step_cyc();
        exp_t e;
        exp_q.push_back(model_step());
        @(posedge i_clk);
        #1;
        e = exp_q.pop_front();
        chk("pos", 32'(o_pos), 32'(e.pos));
        chk("sel", 32'(o_sel), 32'(e.sel));
        chk("blank", 32'(o_blank), 32'(e.blank));
        chk("tick", 32'(o_slot_tick), 32'(e.tick));
        if (o_slot_tick) tick_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cyc();
    endtask

    // Asynchronous reset, checked before any clock edge
    task automatic apply_reset();
        i_rst_n = 1'b0;
        m_cnt   = 0;
        m_pos   = N - 1;
        #1;
        chk("rst_pos", 32'(o_pos), 32'd3);
        chk("rst_sel", 32'(o_sel), 32'hF);
        chk("rst_blank", 32'(o_blank), 32'd1);
        chk("rst_tick", 32'(o_slot_tick), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; tick_cnt = 0;
        i_rst_n = 1'b1; i_en = 1'b1; i_dir = 1'b0; i_digit_mask = 4'b1111;
        m_cnt = 0; m_pos = N - 1;
        #2;

        // Descending full scan
        apply_reset();
        tick_cnt = 0;
        run(4);
        chk("s1_first_adv", 32'(o_pos), 32'd2);
        run(12);
        chk("s1_ticks", 32'(tick_cnt), 32'd4);
        chk("s1_wrap_pos", 32'(o_pos), 32'd3);

        // Ascending, then a mid-slot direction toggle
        i_dir = 1'b1;
        run(4);
        chk("s2_up_pos", 32'(o_pos), 32'd0);
        run(2);
        i_dir = 1'b0;
        run(1);
        chk("s2_mid_hold", 32'(o_pos), 32'd0);
        run(1);
        chk("s2_dir_at_bnd", 32'(o_pos), 32'd3);
        i_dir = 1'b1;
        run(8);

        // Masked digits are skipped and dark
        i_dir = 1'b0; i_digit_mask = 4'b0101;
        apply_reset();
        run(3);
        chk("s3_dark_slot", 32'(o_blank), 32'd1);
        run(1);
        chk("s3_skip_to2", 32'(o_pos), 32'd2);
        run(4);
        chk("s3_skip_to0", 32'(o_pos), 32'd0);
        run(8);

        // All digits masked: position holds, ticks continue
        i_digit_mask = 4'b0000;
        tick_cnt = 0;
        run(20);
        chk("s4_ticks", 32'(tick_cnt), 32'd5);
        i_digit_mask = 4'b1111;
        run(8);

        // Drop enable mid-slot, then resume on the same position
        while (m_cnt != 2) step_cyc();
        i_en = 1'b0;
        tick_cnt = 0;
        run(3);
        i_en = 1'b1;
        run(3);
        chk("s5_no_ticks", 32'(tick_cnt), 32'd0);
        run(6);

        // Reset between clock edges mid-slot
        run(2);
        #2;
        apply_reset();
        tick_cnt = 0;
        run(16);
        chk("s6_ticks", 32'(tick_cnt), 32'd4);

        // Random mask/direction/enable traffic against the model
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 5) == 0) i_digit_mask = 4'($urandom);
            if ($urandom_range(0, 7) == 0) i_dir = 1'($urandom);
            i_en = ($urandom_range(0, 9) != 0);
            step_cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
